// File: rtl/osc_cnt_pkg.sv
// Shared types and defaults for the ring-oscillator edge counter.
// Build option: OSC_GATE_EN (see osc_edge_counter).
package osc_cnt_pkg;

   localparam int unsigned CNT_W_DEF      = 16;
   localparam int unsigned WIN_W_DEF      = 12;
   localparam int unsigned SETTLE_CYC_DEF = 8;

   localparam int unsigned StateW = 2;

   typedef enum logic [StateW-1:0] {
      StIdle,
      StSettle,
      StCount,
      StDone
   } osc_state_e;

   function automatic logic state_is_busy(input osc_state_e st);
      return (st == StSettle) || (st == StCount);
   endfunction

endpackage

// File: rtl/osc_sync_edge.sv
// Two-flop synchroniser for the free-running oscillator, plus a third flop for rising-edge detect.
// Build option: none.
module osc_sync_edge (
   input  logic CLK,
   input  logic RST,
   input  logic ASYNC_IN,
   output logic EDGE
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic s3_q, s3_d;

   always_comb begin
      s1_d = ASYNC_IN;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign EDGE = s2_q & ~s3_q;

endmodule

// File: rtl/osc_edge_counter.sv
// Counts synchronised oscillator rising edges over a WIN_LEN-cycle window with saturation.
// Build option: OSC_GATE_EN gates the oscillator and inserts a SETTLE_CYC warm-up phase.
module osc_edge_counter
   import osc_cnt_pkg::*;
#(
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned WIN_W      = WIN_W_DEF,
   parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             OSC_IN,
   input  logic             START,
   input  logic [WIN_W-1:0] WIN_LEN,
   output logic             BUSY,
   output logic             DONE,
   output logic [CNT_W-1:0] COUNT,
   output logic             OVF,
   output logic             OSC_EN
);

`ifdef OSC_GATE_EN
   localparam bit GateEn = 1'b1;
`else
   localparam bit GateEn = 1'b0;
`endif

   localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] CntMax = '1;

   osc_state_e       state_q, state_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [SetW-1:0]  settle_q, settle_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             osc_edge;

   osc_sync_edge u_sync_edge (
      .CLK      (CLK),
      .RST      (RST),
      .ASYNC_IN (OSC_IN),
      .EDGE     (osc_edge)
   );

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      settle_d = settle_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (START) begin
               win_d    = WIN_LEN;
               settle_d = SetW'(SETTLE_CYC);
               cnt_d    = '0;
               ovf_d    = 1'b0;
               if (GateEn && (SETTLE_CYC != 0)) begin
                  state_d = StSettle;
               end else if (WIN_LEN == '0) begin
                  state_d = StDone;
               end else begin
                  state_d = StCount;
               end
            end
         end
         StSettle: begin
            // Counter holds remaining warm-up cycles including the current one.
            if (settle_q <= SetW'(1)) begin
               state_d = (win_q == '0) ? StDone : StCount;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         StCount: begin
            if (osc_edge && (cnt_q != CntMax)) begin
               cnt_d = cnt_q + 1'b1;
            end
            ovf_d = ovf_q | (cnt_d == CntMax);
            if (win_q <= WIN_W'(1)) begin
               state_d = StDone;
            end else begin
               win_d = win_q - 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= StIdle;
         win_q    <= '0;
         settle_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         settle_q <= settle_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      BUSY   = state_is_busy(state_q);
      DONE   = (state_q == StDone);
      COUNT  = cnt_q;
      OVF    = ovf_q;
      OSC_EN = GateEn ? BUSY : 1'b1;
   end

endmodule

// File: tb/tb_osc_edge_counter.sv
// Directed bench for osc_edge_counter: default instance plus a 4-bit counter instance.
// Honours OSC_GATE_EN when compiled with it.
module tb_osc_edge_counter;

`ifdef OSC_GATE_EN
   localparam int  SettleAdd    = 8;
   localparam logic OscEnIdle   = 1'b0;
`else
   localparam int  SettleAdd    = 0;
   localparam logic OscEnIdle   = 1'b1;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        osc = 1'b0;
   int          osc_half = 4;

   logic        start_a = 1'b0, start_b = 1'b0;
   logic [11:0] win_a = '0, win_b = '0;
   logic        busy_a, done_a, ovf_a, oscen_a;
   logic        busy_b, done_b, ovf_b, oscen_b;
   logic [15:0] count_a;
   logic [3:0]  count_b;

   int n_tests = 0;
   int n_fail  = 0;

   osc_edge_counter u_dut (
      .CLK     (CLK),
      .RST     (RST),
      .OSC_IN  (osc),
      .START   (start_a),
      .WIN_LEN (win_a),
      .BUSY    (busy_a),
      .DONE    (done_a),
      .COUNT   (count_a),
      .OVF     (ovf_a),
      .OSC_EN  (oscen_a)
   );

   osc_edge_counter #(
      .CNT_W (4)
   ) u_dut4 (
      .CLK     (CLK),
      .RST     (RST),
      .OSC_IN  (osc),
      .START   (start_b),
      .WIN_LEN (win_b),
      .BUSY    (busy_b),
      .DONE    (done_b),
      .COUNT   (count_b),
      .OVF     (ovf_b),
      .OSC_EN  (oscen_b)
   );

   always #5 CLK = ~CLK;

   initial begin
      forever begin
         repeat (osc_half) @(negedge CLK);
         osc = ~osc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic get_done(input int sel);
      return (sel == 0) ? done_a : done_b;
   endfunction

   // Returns at the negedge observing cycle t+1 (START accepted at edge t).
   task automatic start_pulse(input int sel, input int win);
      @(negedge CLK);
      if (sel == 0) begin
         start_a = 1'b1;
         win_a   = 12'(win);
      end else begin
         start_b = 1'b1;
         win_b   = 12'(win);
      end
      @(negedge CLK);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_done(input int sel, input int bound, output int lat);
      lat = 1;
      while (!get_done(sel) && (lat < bound)) begin
         @(negedge CLK);
         lat++;
      end
      check("done_seen", 32'(get_done(sel)), 1);
   endtask

   initial begin
      int lat;
      int ndone;
      int first;

      // Reset held for three edges with the oscillator running
      osc_half = 1;
      ndone    = 0;
      repeat (3) begin
         @(negedge CLK);
         if (done_a) ndone++;
      end
      check("rst_no_done", 32'(ndone), 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_done", 32'(done_a), 0);
      check("rst_count", 32'(count_a), 0);
      check("rst_ovf", 32'(ovf_a), 0);
      check("rst_osc_en", 32'(oscen_a), 32'(OscEnIdle));
      RST      = 1'b0;
      osc_half = 4;
      repeat (10) @(negedge CLK);

      // Basic count: period 8, window 64
      start_pulse(0, 64);
      check("cnt_busy_t1", 32'(busy_a), 1);
      check("cnt_osc_en_busy", 32'(oscen_a), 1);
      wait_done(0, 200, lat);
      check("cnt_latency", 32'(lat), 32'(65 + SettleAdd));
      check("cnt_busy_at_done", 32'(busy_a), 0);
      check("cnt_value", 32'(count_a), 8);
      check("cnt_ovf", 32'(ovf_a), 0);
      check("done_osc_en", 32'(oscen_a), 32'(OscEnIdle));
      // START during the DONE cycle must be ignored
      start_a = 1'b1;
      win_a   = 12'd3;
      @(negedge CLK);
      start_a = 1'b0;
      check("start_in_done_busy", 32'(busy_a), 0);
      check("start_in_done_done", 32'(done_a), 0);
      check("cnt_held", 32'(count_a), 8);
      repeat (5) @(negedge CLK);

      // Zero-length window
      start_pulse(0, 0);
      wait_done(0, 50, lat);
      check("zero_latency", 32'(lat), 32'(1 + SettleAdd));
      check("zero_count", 32'(count_a), 0);
      check("zero_ovf", 32'(ovf_a), 0);
      repeat (5) @(negedge CLK);

      // Re-START mid-window is ignored, window length stays latched
      start_pulse(0, 32);
      ndone = 0;
      first = 0;
      for (int i = 1; i <= 60; i++) begin
         if (done_a) begin
            ndone++;
            if (first == 0) first = i;
         end
         start_a = (i == 10);
         if (i == 10) win_a = 12'd5;
         @(negedge CLK);
      end
      check("restart_single_done", 32'(ndone), 1);
      check("restart_latency", 32'(first), 32'(33 + SettleAdd));
      check("restart_count", 32'(count_a), 4);

      // Reset mid-window discards the measurement
      start_pulse(0, 40);
      repeat (9) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check("abort_busy", 32'(busy_a), 0);
      check("abort_count", 32'(count_a), 0);
      check("abort_done", 32'(done_a), 0);
      RST   = 1'b0;
      ndone = 0;
      repeat (60) begin
         @(negedge CLK);
         if (done_a) ndone++;
      end
      check("abort_no_done", 32'(ndone), 0);

`ifdef OSC_GATE_EN
      // Gated oscillator: settle phase precedes a 16-cycle window
      start_pulse(0, 16);
      check("gate_osc_en_t1", 32'(oscen_a), 1);
      wait_done(0, 100, lat);
      check("gate_latency", 32'(lat), 25);
      check("gate_osc_en_done", 32'(oscen_a), 0);
      check("gate_count", 32'(count_a), 2);
      repeat (5) @(negedge CLK);
`endif

      // Saturation with a 4-bit counter, then a clean run
      osc_half = 2;
      repeat (10) @(negedge CLK);
      start_pulse(1, 100);
      wait_done(1, 300, lat);
      check("sat_latency", 32'(lat), 32'(101 + SettleAdd));
      check("sat_count", 32'(count_b), 15);
      check("sat_ovf", 32'(ovf_b), 1);
      repeat (5) @(negedge CLK);
      start_pulse(1, 8);
      check("sat2_ovf_cleared", 32'(ovf_b), 0);
      wait_done(1, 100, lat);
      check("sat2_latency", 32'(lat), 32'(9 + SettleAdd));
      check("sat2_count", 32'(count_b), 2);
      check("sat2_ovf", 32'(ovf_b), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
